// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite encodings and SRAM slave state type
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01
   } hresp_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'b000,
      HSIZE_HALF = 3'b001,
      HSIZE_WORD = 3'b010
   } hsize_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001,
      HBURST_WRAP4  = 3'b010,
      HBURST_INCR4  = 3'b011,
      HBURST_WRAP8  = 3'b100,
      HBURST_INCR8  = 3'b101,
      HBURST_WRAP16 = 3'b110,
      HBURST_INCR16 = 3'b111
   } hburst_e;

   typedef enum logic [2:0] {
      SLV_IDLE = 3'd0,
      SLV_WAIT = 3'd1,
      SLV_DATA = 3'd2,
      SLV_ERR1 = 3'd3,
      SLV_ERR2 = 3'd4
   } slv_state_e;

   // Little-endian byte lanes touched by an aligned transfer of the given size.
   function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] lo);
      logic [3:0] lanes;
      case (size)
         HSIZE_BYTE: lanes = 4'b0001 << lo;
         HSIZE_HALF: lanes = lo[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: lanes = 4'b1111;
         default:    lanes = 4'b0000;
      endcase
      return lanes;
   endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// rtl/ahb_sram_slave_if.sv - AHB-Lite bus signals between a master and the SRAM slave
interface ahb_sram_slave_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  HSEL;
   logic [ADDR_WIDTH-1:0] HADDR;
   logic [1:0]            HTRANS;
   logic                  HWRITE;
   logic [2:0]            HSIZE;
   logic [2:0]            HBURST;
   logic [3:0]            HPROT;
   logic [DATA_WIDTH-1:0] HWDATA;
   logic                  HREADY;
   logic                  HREADYOUT;
   logic [1:0]            HRESP;
   logic [DATA_WIDTH-1:0] HRDATA;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
      input  HREADYOUT, HRESP, HRDATA
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
      output HREADYOUT, HRESP, HRDATA
   );
endinterface

// File: rtl/ahb_sram_mem.sv
// rtl/ahb_sram_mem.sv - word SRAM with byte write enables and combinational read
module ahb_sram_mem #(
   parameter int DEPTH = 1024,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic [3:0]       we_i,
   input  logic [IDX_W-1:0] waddr_i,
   input  logic [31:0]      wdata_i,
   input  logic [IDX_W-1:0] raddr_i,
   output logic [31:0]      rdata_o
);
   logic [31:0] mem_q [DEPTH];

   // Commit only the enabled byte lanes; contents survive reset.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < 4; b++) begin
         if (we_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM completer with wait states and ERROR response
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_STATES = 0
) (
   input logic             HCLK,
   input logic             HRESETn,
   ahb_sram_slave_if.slave bus
);
   localparam int          IDX_W     = $clog2(MEM_DEPTH);
   localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'd4;

   slv_state_e            state_q, state_d;
   logic [3:0]            wait_q, wait_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  write_q, write_d;
   logic [2:0]            size_q, size_d;
   logic                  accept;
   logic                  xfer_err;
   logic [3:0]            wr_be;
   logic [DATA_WIDTH-1:0] rdata_w;
   logic                  unused_bits;

   assign accept = bus.HSEL && bus.HREADY && bus.HTRANS[1];

   // Classify the address phase: out of range, unsupported size or misaligned.
   always_comb begin
      xfer_err = (64'(bus.HADDR) >= MEM_BYTES)
              || (bus.HSIZE > HSIZE_WORD)
              || ((bus.HSIZE == HSIZE_HALF) && bus.HADDR[0])
              || ((bus.HSIZE == HSIZE_WORD) && (bus.HADDR[1:0] != 2'b00));
   end

   // Data-phase state, wait counter and latched address-phase control.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= SLV_IDLE;
         wait_q  <= 4'd0;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= 3'b000;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         size_q  <= size_d;
      end
   end

   // Next state: states that present HREADYOUT=1 also sample the next address phase.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      addr_d  = addr_q;
      write_d = write_q;
      size_d  = size_q;
      case (state_q)
         SLV_WAIT: begin
            wait_d = wait_q - 4'd1;
            if (wait_q == 4'd1) state_d = SLV_DATA;
         end
         SLV_ERR1: state_d = SLV_ERR2;
         default: begin
            state_d = SLV_IDLE;
            if (accept) begin
               addr_d  = bus.HADDR;
               write_d = bus.HWRITE;
               size_d  = bus.HSIZE;
               if (xfer_err) begin
                  state_d = SLV_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_d = SLV_WAIT;
                  wait_d  = 4'(WAIT_STATES);
               end else begin
                  state_d = SLV_DATA;
               end
            end
         end
      endcase
   end

   assign wr_be = ((state_q == SLV_DATA) && write_q) ? byte_lanes(size_q, addr_q[1:0]) : 4'b0000;

   ahb_sram_mem #(
      .DEPTH (MEM_DEPTH),
      .IDX_W (IDX_W)
   ) u_mem (
      .clk_i   (HCLK),
      .we_i    (wr_be),
      .waddr_i (addr_q[IDX_W+1:2]),
      .wdata_i (bus.HWDATA),
      .raddr_i (addr_q[IDX_W+1:2]),
      .rdata_o (rdata_w)
   );

   assign bus.HREADYOUT = !((state_q == SLV_WAIT) || (state_q == SLV_ERR1));
   assign bus.HRESP     = ((state_q == SLV_ERR1) || (state_q == SLV_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
   assign bus.HRDATA    = ((state_q == SLV_DATA) && !write_q) ? rdata_w : '0;

   assign unused_bits = ^{bus.HBURST, bus.HPROT, addr_q[ADDR_WIDTH-1:IDX_W+2]};
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - directed bench with a transfer-level AHB SRAM model
module tb_ahb_sram_slave;
   logic HCLK = 1'b0;
   logic rstn = 1'b0;
   always #5 HCLK = ~HCLK;

   // Master-side drive, shared by two slaves; sel picks which one is addressed.
   logic        sel = 1'b0;
   logic        b_hsel = 1'b0;
   logic [31:0] b_haddr = '0;
   logic [1:0]  b_htrans = 2'b00;
   logic        b_hwrite = 1'b0;
   logic [2:0]  b_hsize = 3'b000;
   logic [31:0] b_hwdata = '0;
   logic        bus_ready;
   logic        o_ready;
   logic [1:0]  o_resp;
   logic [31:0] o_rdata;

   ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
   ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if3 ();

   assign bus_ready = sel ? if3.HREADYOUT : if0.HREADYOUT;
   assign o_ready   = bus_ready;
   assign o_resp    = sel ? if3.HRESP : if0.HRESP;
   assign o_rdata   = sel ? if3.HRDATA : if0.HRDATA;

   assign if0.HSEL = b_hsel & ~sel;
   assign if3.HSEL = b_hsel & sel;
   assign if0.HADDR = b_haddr;    assign if3.HADDR = b_haddr;
   assign if0.HTRANS = b_htrans;  assign if3.HTRANS = b_htrans;
   assign if0.HWRITE = b_hwrite;  assign if3.HWRITE = b_hwrite;
   assign if0.HSIZE = b_hsize;    assign if3.HSIZE = b_hsize;
   assign if0.HBURST = 3'b011;    assign if3.HBURST = 3'b011;
   assign if0.HPROT = 4'b0011;    assign if3.HPROT = 4'b0011;
   assign if0.HWDATA = b_hwdata;  assign if3.HWDATA = b_hwdata;
   assign if0.HREADY = bus_ready; assign if3.HREADY = bus_ready;

   ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
      .HCLK    (HCLK),
      .HRESETn (rstn),
      .bus     (if0.slave)
   );

   ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(3)) u_dut3 (
      .HCLK    (HCLK),
      .HRESETn (rstn),
      .bus     (if3.slave)
   );

   int n_checks = 0;
   int n_fail = 0;
   int low_cnt = 0;
   int err_cnt = 0;
   logic [31:0] last_rdata = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: byte memory per slave, and a queue of expected data-phase cycles.
   bit [7:0] mref [2][4096];

   typedef struct {
      bit        rdy;
      bit [1:0]  resp;
      bit        rd;
      bit        wr;
      int        d;
      bit [31:0] addr;
      bit [2:0]  size;
   } cyc_t;

   cyc_t exp_q[$];
   cyc_t mc;
   bit   m_acc;

   function automatic bit [31:0] mword(input int d, input bit [31:0] a);
      bit [31:0] w;
      int base;
      base = int'(a) / 4 * 4;
      for (int k = 0; k < 4; k++) w[8*k +: 8] = mref[d][base + k];
      return w;
   endfunction

   function automatic bit is_bad(input bit [31:0] a, input bit [2:0] s);
      if (a >= 32'd4096) return 1'b1;
      if (s > 3'd2) return 1'b1;
      return (a % (32'd1 << s)) != 0;
   endfunction

   always @(posedge HCLK or negedge rstn) begin
      if (!rstn) begin
         exp_q.delete();
      end else begin
         m_acc = b_hsel && b_htrans[1] && ((exp_q.size() == 0) || exp_q[0].rdy);
         if (exp_q.size() > 0) begin
            mc = exp_q.pop_front();
            if (mc.wr) begin
               for (int k = 0; k < (1 << mc.size); k++) begin
                  int a;
                  a = int'(mc.addr) + k;
                  mref[mc.d][a] = b_hwdata[8*(a % 4) +: 8];
               end
            end
         end
         if (m_acc) begin
            if (is_bad(b_haddr, b_hsize)) begin
               mc = '{rdy: 1'b0, resp: 2'b01, rd: 1'b0, wr: 1'b0, d: 0, addr: 0, size: 0};
               exp_q.push_back(mc);
               mc.rdy = 1'b1;
               exp_q.push_back(mc);
            end else begin
               for (int w = 0; w < (sel ? 3 : 0); w++) begin
                  mc = '{rdy: 1'b0, resp: 2'b00, rd: 1'b0, wr: 1'b0, d: 0, addr: 0, size: 0};
                  exp_q.push_back(mc);
               end
               mc = '{rdy: 1'b1, resp: 2'b00, rd: !b_hwrite, wr: b_hwrite,
                      d: (sel ? 1 : 0), addr: b_haddr, size: b_hsize};
               exp_q.push_back(mc);
            end
         end
      end
   end

   // Compare the addressed slave against the model on every cycle out of reset.
   always @(negedge HCLK) begin
      bit        e_rdy;
      bit [1:0]  e_resp;
      bit [31:0] e_data;
      bit        rd_now;
      if (rstn) begin
         e_rdy = 1'b1; e_resp = 2'b00; e_data = '0; rd_now = 1'b0;
         if (exp_q.size() > 0) begin
            e_rdy  = exp_q[0].rdy;
            e_resp = exp_q[0].resp;
            if (exp_q[0].rd) begin
               e_data = mword(exp_q[0].d, exp_q[0].addr);
               rd_now = 1'b1;
            end
         end
         chk("hreadyout", 32'(o_ready), 32'(e_rdy));
         chk("hresp", 32'(o_resp), 32'(e_resp));
         chk("hrdata", o_rdata, e_data);
         if (rd_now) last_rdata = o_rdata;
         if (!o_ready) low_cnt++;
         if (o_resp == 2'b01) err_cnt++;
      end
   end

   // Stimulus: a queue of transfers issued with full address/data pipelining.
   typedef struct {
      bit [31:0] addr;
      bit        wr;
      bit [2:0]  size;
      bit [31:0] wdata;
      bit [1:0]  trans;
   } xfer_t;

   xfer_t seq[$];

   task automatic add(input bit [31:0] a, input bit w, input bit [2:0] s,
                      input bit [31:0] wd, input bit [1:0] t);
      xfer_t x;
      x = '{addr: a, wr: w, size: s, wdata: wd, trans: t};
      seq.push_back(x);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge HCLK);
      while (!bus_ready && n < 100) begin
         n++;
         @(negedge HCLK);
      end
      if (n >= 100) begin
         n_checks++;
         n_fail++;
         $display("FAIL ready_timeout: HREADYOUT stuck low, required high within 100 cycles");
      end
   endtask

   task automatic run_seq();
      for (int i = 0; i <= seq.size(); i++) begin
         if (i < seq.size()) begin
            b_hsel = 1'b1; b_haddr = seq[i].addr; b_htrans = seq[i].trans;
            b_hwrite = seq[i].wr; b_hsize = seq[i].size;
         end else begin
            b_hsel = 1'b0; b_htrans = 2'b00; b_hwrite = 1'b0;
         end
         wait_ready();
         @(posedge HCLK);
         #1;
         if (i < seq.size()) b_hwdata = seq[i].wdata;
      end
      seq.delete();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, required finish before 400000");
      $fatal(1, "watchdog");
   end

   localparam bit [1:0] NS = 2'b10, SQ = 2'b11, BZ = 2'b01;
   localparam bit [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

   initial begin
      repeat (2) @(posedge HCLK);
      #1;
      chk("rst_ready0", 32'(if0.HREADYOUT), 32'd1);
      chk("rst_resp0", 32'(if0.HRESP), 32'd0);
      chk("rst_rdata0", if0.HRDATA, 32'd0);
      chk("rst_ready3", 32'(if3.HREADYOUT), 32'd1);
      chk("rst_resp3", 32'(if3.HRESP), 32'd0);
      chk("rst_rdata3", if3.HRDATA, 32'd0);
      rstn = 1'b1;
      @(posedge HCLK); #1;

      // Zero-wait write then read, back to back.
      sel = 1'b0;
      add(32'h10, 1, SW, 32'hDEADBEEF, NS);
      add(32'h10, 0, SW, 32'h0, NS);
      run_seq();
      chk("t1_rdata", last_rdata, 32'hDEADBEEF);

      // Byte and halfword lanes merged into a zeroed word.
      add(32'h20, 1, SW, 32'h00000000, NS);
      add(32'h21, 1, SB, 32'hAAAAAAAA, NS);
      add(32'h22, 1, SH, 32'h12341234, NS);
      add(32'h20, 0, SW, 32'h0, NS);
      run_seq();
      chk("t2_rdata", last_rdata, 32'h1234AA00);

      // Out-of-range read: two ERROR cycles, then OKAY on idle.
      err_cnt = 0;
      add(32'h1000, 0, SW, 32'h0, NS);
      run_seq();
      chk("t4_err_cycles", 32'(err_cnt), 32'd2);
      add(32'h10, 0, SW, 32'h0, NS);
      run_seq();
      chk("t4_mem_kept", last_rdata, 32'hDEADBEEF);

      // Burst crossing the top of memory, with a BUSY beat in between.
      add(32'hFFC, 1, SW, 32'h55AA55AA, NS);
      add(32'h1000, 1, SW, 32'hFFFFFFFF, BZ);
      add(32'h1000, 1, SW, 32'hFFFFFFFF, SQ);
      add(32'hFFC, 0, SW, 32'h0, NS);
      run_seq();
      chk("t4_burst_top", last_rdata, 32'h55AA55AA);

      // Misaligned word write and illegal size.
      err_cnt = 0;
      add(32'h100, 1, SW, 32'hCAFEF00D, NS);
      add(32'h102, 1, SW, 32'hBADBAD00, NS);
      add(32'h101, 1, SH, 32'h77777777, NS);
      add(32'h104, 0, 3'b011, 32'h0, NS);
      add(32'h100, 0, SW, 32'h0, NS);
      run_seq();
      chk("t5_err_cycles", 32'(err_cnt), 32'd6);
      chk("t5_mem_kept", last_rdata, 32'hCAFEF00D);

      // Three wait states: single read, then an INCR4 read.
      sel = 1'b1;
      add(32'h40, 1, SW, 32'h11110040, NS);
      add(32'h44, 1, SW, 32'h22220044, SQ);
      add(32'h48, 1, SW, 32'h33330048, SQ);
      add(32'h4C, 1, SW, 32'h4444004C, SQ);
      run_seq();
      low_cnt = 0;
      add(32'h44, 0, SW, 32'h0, NS);
      run_seq();
      chk("t3_single_waits", 32'(low_cnt), 32'd3);
      chk("t3_single_rdata", last_rdata, 32'h22220044);
      low_cnt = 0;
      add(32'h40, 0, SW, 32'h0, NS);
      add(32'h44, 0, SW, 32'h0, SQ);
      add(32'h48, 0, SW, 32'h0, SQ);
      add(32'h4C, 0, SW, 32'h0, SQ);
      run_seq();
      chk("t3_burst_waits", 32'(low_cnt), 32'd12);
      chk("t3_burst_last", last_rdata, 32'h4444004C);

      // Reset asserted while a write sits in its wait states.
      add(32'h80, 1, SW, 32'h11111111, NS);
      run_seq();
      b_hsel = 1'b1; b_haddr = 32'h80; b_htrans = NS; b_hwrite = 1'b1; b_hsize = SW;
      wait_ready();
      @(posedge HCLK); #1;
      b_hwdata = 32'h22222222;
      b_hsel = 1'b0; b_htrans = 2'b00; b_hwrite = 1'b0;
      @(negedge HCLK);
      chk("t6_in_wait", 32'(o_ready), 32'd0);
      #2 rstn = 1'b0;
      #1;
      chk("t6_rst_ready", 32'(o_ready), 32'd1);
      chk("t6_rst_resp", 32'(o_resp), 32'd0);
      chk("t6_rst_rdata", o_rdata, 32'd0);
      repeat (2) @(posedge HCLK);
      #1 rstn = 1'b1;
      add(32'h80, 0, SW, 32'h0, NS);
      run_seq();
      chk("t6_old_data", last_rdata, 32'h11111111);

      repeat (2) @(posedge HCLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
AHB-Lite completer (slave) fronting an on-chip word-organised SRAM. It is the responder counterpart to the team's ahb_master and sits behind the address decoder on the same HCLK domain. It supports:
- single and burst transfers of byte, halfword and word size;
- a configurable number of wait states;
- the two-cycle ERROR response on out-of-range or misaligned accesses.

Parameters:
ADDR_WIDTH, 32, width of HADDR
DATA_WIDTH, 32, width of HWDATA/HRDATA; only 32 is supported
MEM_DEPTH, 1024, number of DATA_WIDTH words; byte range 0 to MEM_DEPTH*4-1 is legal
WAIT_STATES, 0, HREADYOUT-low cycles inserted per valid transfer, range 0..15

Ports:
HCLK  input  1  clock, all logic on the rising edge
HRESETn  input  1  asynchronous, active-low reset
HSEL  input  1  slave select from the decoder
HADDR  input  ADDR_WIDTH  byte address (address phase)
HTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
HWRITE  input  1  1=write, 0=read
HSIZE  input  3  000=byte, 001=half, 010=word
HBURST  input  3  burst type; accepted but not used by this slave
HPROT  input  4  protection; ignored
HWDATA  input  DATA_WIDTH  write data (data phase)
HREADY  input  1  bus HREADY; gates address-phase sampling
HREADYOUT  output  1  slave ready
HRESP  output  2  OKAY=00, ERROR=01
HRDATA  output  DATA_WIDTH  read data

Behaviour:
Reset values and reset mid-transfer:
- On reset: HREADYOUT=1, HRESP=00, HRDATA=0, FSM=IDLE, wait counter=0, latched control=0.
- Memory contents are not cleared by reset.
- Reset during any data phase aborts the transfer; no memory write occurs.

Transfer acceptance:
- A transfer is accepted on an edge where HSEL && HREADY && HTRANS[1].
- On acceptance, latch HADDR, HWRITE and HSIZE into the data-phase registers.
- IDLE and BUSY transfers, or a deselected slave: next cycle is HREADYOUT=1, HRESP=OKAY, with no side effect.

Error check (at acceptance):
- The transfer is erroneous if any of these holds:
  - HADDR >= MEM_DEPTH*4;
  - HSIZE > 010;
  - misaligned: HSIZE=001 with HADDR[0]=1, or HSIZE=010 with HADDR[1:0]!=00.
- An erroneous transfer never touches memory.

FSM states:
- IDLE:
  - Accept a valid transfer → WAIT if WAIT_STATES>0, otherwise → DATA.
  - Accept an erroneous transfer → ERR1.
- WAIT:
  - HREADYOUT=0, HRESP=OKAY.
  - The counter is loaded with WAIT_STATES at acceptance and decrements each cycle.
  - When the counter reaches 1 → DATA.
- DATA:
  - HREADYOUT=1, HRESP=OKAY; the transfer completes on this edge.
  - Write: commit HWDATA byte lanes selected by latched HSIZE and HADDR[1:0], little-endian.
    - byte: lane = addr[1:0];
    - half: lanes {addr[1],0} and {addr[1],1};
    - word: all four lanes.
  - Read: HRDATA = full memory word at latched addr[ADDR_WIDTH-1:2]; the master selects lanes.
  - A pipelined next transfer may be accepted on the same edge; its next state follows the IDLE rules.
- ERR1: HREADYOUT=0, HRESP=ERROR, unconditionally → ERR2.
- ERR2:
  - HREADYOUT=1, HRESP=ERROR.
  - The address phase is sampled as in IDLE (the master may cancel with IDLE or issue a new transfer).
  - Next state follows the IDLE rules.

Latency and output timing:
- Data phase length is 1+WAIT_STATES cycles for valid transfers and 2 cycles for errors.
- HRDATA is driven only in the completing cycle of a read; otherwise 0.

Read-after-write:
- Memory read is combinational from the array.
- A write committed at the end of its data phase is visible to a read whose data phase immediately follows.
- Required: back-to-back W then R to the same address returns the new data with zero wait.

Burst handling:
- SEQ beats are treated exactly like NONSEQ; the address comes from the master.
- A burst that crosses MEM_DEPTH errors on the first out-of-range beat only.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ;
  - HRESP OKAY/ERROR;
  - HSIZE BYTE/HALF/WORD;
  - HBURST encodings SINGLE..INCR16;
  - the slave FSM state encoding.
- ahb_master reuses the same package.
- One sub-module, ahb_sram_mem: MEM_DEPTH x 32 array with a 4-bit byte-write-enable write port and a combinational read port.
- Protocol FSM, error check and wait counter stay in ahb_sram_slave.

Test Plan:
1. WAIT_STATES=0: word write 0xDEADBEEF to 0x10, then read 0x10 back-to-back → both HREADYOUT=1 on the first data-phase cycle; HRDATA=0xDEADBEEF, HRESP=00.
2. Byte write 0xAA to 0x21, half write 0x1234 to 0x22, over 0x00000000 at 0x20 → read 0x20 returns 0x1234AA00.
3. WAIT_STATES=3: single read → HREADYOUT low exactly 3 cycles then high with data; INCR4 from 0x40 → each beat stretched by 3 cycles, addresses 0x40..0x4C.
4. Read at 0x1000 (MEM_DEPTH=1024) → HREADYOUT=0/HRESP=01, then HREADYOUT=1/HRESP=01; memory unchanged; the following IDLE yields OKAY.
5. Word write to 0x102 (misaligned) → two-cycle ERROR and location 0x100 unchanged; HSIZE=011 → ERROR.
6. Assert HRESETn low during the WAIT state of a write to 0x80 → outputs return to reset values immediately; a later read of 0x80 shows the old contents.
